reflet_reg_ctrl: RTL and testbench
==================================

Name: reflet_reg_ctrl

Overview:
- Parametrised register-file and sequencing core for the next-generation CPU.
- Holds the 16 architectural registers and applies the writeback from the ALU and address units.
- Performs PC and SP bookkeeping, and latches quit.
- New: prioritised, maskable interrupt entry and return, with a handshaked push of the return PC onto the stack.

Parameters:
- wordsize, 16: register width in bits; multiple of 8, 8..64.
- int_number, 4: number of interrupt request lines, 1..8.
- int_vector_base, 4: PC loaded for interrupt 0.
- int_vector_stride, 2: PC distance between consecutive vectors.
- sp_reset_val, 0: SP value after reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- instruction  in  8  current instruction; [7:4] opcode, [3:0] argument register id.
- wb_index  in  4  register to write; OR of the ALU and address-unit indices.
- wb_content  in  wordsize  value to write; OR of the ALU and address-unit contents.
- ram_not_ready  in  1  high = the current instruction has not completed; hold all state.
- int_req  in  int_number  level-sensitive interrupt requests.
- int_push_ready  in  1  bus accepted the interrupt return-PC push.
- wr_out, sr_out, pc_out, sp_out  out  wordsize  architectural register values.
- arg_out  out  wordsize  combinational read of registers[instruction[3:0]].
- quit  out  1  set by the quit instruction.
- int_active  out  1  an interrupt handler is running.
- int_push_valid  out  1  return-PC push request.
- int_push_addr  out  wordsize  SP value at push request.
- int_push_data  out  wordsize  PC of the next instruction.

Behaviour:
- Reset (async, reset=0):
  - wr=0, sr=0, pc=0, sp=sp_reset_val, r4..r15=0.
  - quit=0, int_active=0, int_push_valid=0.
  - FSM=RUN.
  - Reset during INT_SAVE aborts the push immediately.
- Register ids: wr=0, sr=1, pc=2, sp=3, general purpose 4..15.
- All arithmetic is modulo 2^wordsize; wrap-around is silent.
- Instruction completes in RUN when ram_not_ready=0. Only then:
  - registers[wb_index] <= wb_content.
  - pc <= pc+1, unless wb_index==pc_id.
  - SP step for data accesses, selected by sr[2:1]:
    - 00: wordsize/8
    - 01: min(4, wordsize/8)
    - 10: min(2, wordsize/8)
    - 11: 1
  - Address step is always wordsize/8.
  - push: sp += data step.
  - pop: sp -= data step, then write.
  - call: sp += address step, then write.
  - ret: sp -= address step, then write.
  - retint: behaves as ret and also clears int_active.
  - An explicit write to sp_id on push/pop/call/ret/retint is overridden by the step update.
  - quit: quit<=1, FSM -> QUIT.
- FSM states:
  - RUN: normal execution.
  - INT_SAVE: return-PC push in progress.
  - QUIT: absorbing until reset; no register changes; interrupts ignored.
- Interrupt entry:
  - Condition: instruction completes in RUN, sr[3]=1, int_active=0, and int_req!=0.
  - The instruction's own writeback and PC/SP update happen first.
  - Then FSM -> INT_SAVE, latching the lowest-index asserted request i (priority).
- INT_SAVE:
  - int_push_valid=1, int_push_addr=sp, int_push_data=pc (updated value).
  - On int_push_ready=1: sp += wordsize/8, pc <= int_vector_base + i*int_vector_stride, int_active<=1, push_valid<=0, FSM -> RUN.
  - Latency from ready to first handler instruction: 1 cycle.
- Requests are sampled only at completion; a request dropped before completion is lost.
- Quit and an interrupt in the same cycle: quit wins, no entry.
- Nested interrupts are blocked while int_active=1.
- ram_not_ready=1 holds all state in every FSM state, and defers interrupt entry.

Decomposition:
- Shared header `asrm.vh`:
  - register ids
  - reset values
  - opcode constants: inst_quit, inst_push, inst_pop, inst_call, inst_ret, inst_retint
  - sr bit positions: reduced-behaviour [2:1], interrupt enable 3
  - FSM state encodings
- Sub-module reflet_int_prio: combinational lowest-index priority encoder over int_req, giving index and a valid flag; parametrised by int_number.

Test Plan:
- Reset (reset=0 mid-run) -> all outputs at reset values asynchronously, without waiting for clk; then ALU write wb_index=4, 0x1234 -> r4=0x1234, pc 0->1.
- wordsize=32:
  - sr[2:1]=01, push then pop from sp=0x100 -> sp 0x104, then 0x100.
  - sr[2:1]=11, push from sp=0x100 -> sp 0x101.
- sp=0xFFFF, wordsize=16, push with default step -> sp 0x0001 (wrap); write wb_index=pc_id value 0x40 -> pc=0x40, no increment.
- sr[3]=1, pc=0x10, int_req=4'b0110, int_push_ready held low 3 cycles:
  - push_valid high, push_data=0x11, state held.
  - Ready then high -> pc=4+1*2=6, int_active=1.
  - retint popping 0x11 -> pc=0x11, int_active=0.
- Quit instruction with int_req=1, sr[3]=1 -> quit=1, no push_valid, registers frozen for 10 cycles despite instructions.
- ram_not_ready=1 for 5 cycles with a pending interrupt -> no register or pc change and no entry; entry follows completion.

Source files
------------

// File: rtl/reflet_reg_ctrl_pkg.sv
// reflet_reg_ctrl_pkg
//   Shared constants and types for the Reflet register/sequencing core:
//   architectural register ids, reset values, opcodes of the stack and
//   control instructions, status-register bit positions, FSM states and
//   the data-access SP step helper.
package reflet_reg_ctrl_pkg;

  // Architectural register ids
  localparam logic [3:0] WR_ID = 4'd0;
  localparam logic [3:0] SR_ID = 4'd1;
  localparam logic [3:0] PC_ID = 4'd2;
  localparam logic [3:0] SP_ID = 4'd3;

  // Reset value of every register except SP (SP has its own parameter)
  localparam int REG_RST_VAL = 0;

  // Full-byte opcodes of the instructions the sequencer acts on
  localparam logic [7:0] INST_RETINT = 8'h01;
  localparam logic [7:0] INST_POP    = 8'h0A;
  localparam logic [7:0] INST_PUSH   = 8'h0B;
  localparam logic [7:0] INST_CALL   = 8'h0C;
  localparam logic [7:0] INST_RET    = 8'h0D;
  localparam logic [7:0] INST_QUIT   = 8'h0E;

  // Status register fields: [2:1] reduced-behaviour size, [3] int enable
  localparam int SR_MODE_LSB = 1;
  localparam int SR_INT_EN   = 3;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_INT_SAVE = 2'd1,
    ST_QUIT     = 2'd2
  } state_e;

  // SP step for push/pop: the access size is capped by the reduced mode
  function automatic int data_step(input logic [1:0] mode, input int bytes);
    case (mode)
      2'b00:   return bytes;
      2'b01:   return (bytes < 4) ? bytes : 4;
      2'b10:   return (bytes < 2) ? bytes : 2;
      default: return 1;
    endcase
  endfunction

endpackage

// File: rtl/reflet_int_prio.sv
// reflet_int_prio
//   Combinational lowest-index-first priority encoder over the interrupt
//   request lines.
//   i_req  : request lines (int_number bits)
//   o_idx  : index of the lowest asserted line (0 when none)
//   o_vld  : at least one line asserted
module reflet_int_prio #(
  parameter int int_number = 4
) (
  input  logic [int_number-1:0] i_req,
  output logic [2:0]            o_idx,
  output logic                  o_vld
);

  // Scan downward so the lowest asserted index is the last one assigned
  always_comb begin
    o_idx = '0;
    o_vld = 1'b0;
    for (int i = int_number - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_idx = 3'(i);
        o_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reflet_reg_ctrl.sv
// reflet_reg_ctrl
//   Register file and sequencing core: 16 architectural registers,
//   writeback, PC/SP bookkeeping, quit latch, and prioritised maskable
//   interrupt entry with a handshaked push of the return PC.
//   clk, reset            : clock, async active-low reset
//   instruction           : [7:4] opcode, [3:0] argument register id
//   wb_index/wb_content   : register writeback (OR of ALU and address unit)
//   ram_not_ready         : current instruction not complete, hold state
//   int_req               : level-sensitive interrupt requests
//   int_push_ready        : bus accepted the return-PC push
//   wr/sr/pc/sp_out       : architectural register values
//   arg_out               : registers[instruction[3:0]]
//   quit, int_active      : status flags
//   int_push_valid/addr/data : return-PC push request (addr=sp, data=pc)
module reflet_reg_ctrl
  import reflet_reg_ctrl_pkg::*;
#(
  parameter int wordsize          = 16,
  parameter int int_number        = 4,
  parameter int int_vector_base   = 4,
  parameter int int_vector_stride = 2,
  parameter int sp_reset_val      = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            instruction,
  input  logic [3:0]            wb_index,
  input  logic [wordsize-1:0]   wb_content,
  input  logic                  ram_not_ready,
  input  logic [int_number-1:0] int_req,
  input  logic                  int_push_ready,
  output logic [wordsize-1:0]   wr_out,
  output logic [wordsize-1:0]   sr_out,
  output logic [wordsize-1:0]   pc_out,
  output logic [wordsize-1:0]   sp_out,
  output logic [wordsize-1:0]   arg_out,
  output logic                  quit,
  output logic                  int_active,
  output logic                  int_push_valid,
  output logic [wordsize-1:0]   int_push_addr,
  output logic [wordsize-1:0]   int_push_data
);

  localparam int BYTES = wordsize / 8;

  logic [wordsize-1:0] r_regs [16];
  state_e              r_state;
  state_e              w_state_nxt;
  logic                r_quit;
  logic                r_int_active;
  logic                r_push_valid;
  logic [2:0]          r_int_idx;

  logic [2:0]          w_prio_idx;
  logic                w_prio_vld;
  logic                w_complete;
  logic                w_int_take;
  logic                w_push_done;
  logic                w_is_quit;
  logic [wordsize-1:0] w_dstep;
  logic [wordsize-1:0] w_astep;
  logic [wordsize-1:0] w_vector;

  reflet_int_prio #(.int_number(int_number)) u_prio (
    .i_req (int_req),
    .o_idx (w_prio_idx),
    .o_vld (w_prio_vld)
  );

  assign w_complete  = (r_state == ST_RUN) && !ram_not_ready;
  assign w_is_quit   = (instruction == INST_QUIT);
  // Quit beats interrupt entry; nesting blocked while a handler runs
  assign w_int_take  = w_complete && !w_is_quit && r_regs[SR_ID][SR_INT_EN]
                       && !r_int_active && w_prio_vld;
  assign w_push_done = (r_state == ST_INT_SAVE) && !ram_not_ready && int_push_ready;
  assign w_dstep     = wordsize'(data_step(r_regs[SR_ID][SR_MODE_LSB +: 2], BYTES));
  assign w_astep     = wordsize'(BYTES);
  assign w_vector    = wordsize'(int_vector_base + int'(r_int_idx) * int_vector_stride);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_RUN;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN: begin
        if (w_complete && w_is_quit) w_state_nxt = ST_QUIT;
        else if (w_int_take)         w_state_nxt = ST_INT_SAVE;
      end
      ST_INT_SAVE: if (w_push_done) w_state_nxt = ST_RUN;
      default: ;
    endcase
  end

  // Later assignments to pc/sp deliberately override the generic writeback
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) r_regs[i] <= wordsize'(REG_RST_VAL);
      r_regs[SP_ID] <= wordsize'(sp_reset_val);
      r_quit        <= 1'b0;
      r_int_active  <= 1'b0;
      r_push_valid  <= 1'b0;
      r_int_idx     <= '0;
    end else if (w_complete) begin
      r_regs[wb_index] <= wb_content;
      if (wb_index != PC_ID) r_regs[PC_ID] <= r_regs[PC_ID] + wordsize'(1);
      case (instruction)
        INST_PUSH:            r_regs[SP_ID] <= r_regs[SP_ID] + w_dstep;
        INST_POP:             r_regs[SP_ID] <= r_regs[SP_ID] - w_dstep;
        INST_CALL:            r_regs[SP_ID] <= r_regs[SP_ID] + w_astep;
        INST_RET, INST_RETINT: r_regs[SP_ID] <= r_regs[SP_ID] - w_astep;
        default: ;
      endcase
      if (instruction == INST_RETINT) r_int_active <= 1'b0;
      if (w_is_quit) r_quit <= 1'b1;
      if (w_int_take) begin
        r_push_valid <= 1'b1;
        r_int_idx    <= w_prio_idx;
      end
    end else if (w_push_done) begin
      r_regs[SP_ID] <= r_regs[SP_ID] + w_astep;
      r_regs[PC_ID] <= w_vector;
      r_int_active  <= 1'b1;
      r_push_valid  <= 1'b0;
    end
  end

  assign wr_out         = r_regs[WR_ID];
  assign sr_out         = r_regs[SR_ID];
  assign pc_out         = r_regs[PC_ID];
  assign sp_out         = r_regs[SP_ID];
  assign arg_out        = r_regs[instruction[3:0]];
  assign quit           = r_quit;
  assign int_active     = r_int_active;
  assign int_push_valid = r_push_valid;
  // PC here is already the post-increment value of the interrupted instruction
  assign int_push_addr  = r_regs[SP_ID];
  assign int_push_data  = r_regs[PC_ID];

endmodule

// File: tb/tb_reflet_reg_ctrl.sv
module tb_reflet_reg_ctrl;
  import reflet_reg_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // 16-bit DUT (main)
  logic [7:0]  ins = '0;
  logic [3:0]  wbi = '0;
  logic [15:0] wbc = '0;
  logic        rnr = 1'b1;
  logic [3:0]  req = '0;
  logic        rdy = 1'b0;
  logic [15:0] wr_o, sr_o, pc_o, sp_o, arg_o, pa_o, pd_o;
  logic        quit_o, act_o, pv_o;

  reflet_reg_ctrl u_dut (
    .clk(clk), .reset(reset), .instruction(ins), .wb_index(wbi), .wb_content(wbc),
    .ram_not_ready(rnr), .int_req(req), .int_push_ready(rdy),
    .wr_out(wr_o), .sr_out(sr_o), .pc_out(pc_o), .sp_out(sp_o), .arg_out(arg_o),
    .quit(quit_o), .int_active(act_o), .int_push_valid(pv_o),
    .int_push_addr(pa_o), .int_push_data(pd_o)
  );

  // 32-bit DUT for SP-step sizes
  logic [7:0]  s_ins = '0;
  logic [3:0]  s_wbi = '0;
  logic [31:0] s_wbc = '0;
  logic        s_rnr = 1'b1;
  logic [31:0] s_wr, s_sr, s_pc, s_sp, s_arg, s_pa, s_pd;
  logic        s_quit, s_act, s_pv;

  reflet_reg_ctrl #(.wordsize(32)) u_dut32 (
    .clk(clk), .reset(reset), .instruction(s_ins), .wb_index(s_wbi), .wb_content(s_wbc),
    .ram_not_ready(s_rnr), .int_req(4'b0000), .int_push_ready(1'b0),
    .wr_out(s_wr), .sr_out(s_sr), .pc_out(s_pc), .sp_out(s_sp), .arg_out(s_arg),
    .quit(s_quit), .int_active(s_act), .int_push_valid(s_pv),
    .int_push_addr(s_pa), .int_push_data(s_pd)
  );

  int n_cmp = 0;
  int n_fail = 0;

  logic [114:0] dut_vec;
  assign dut_vec = {wr_o, sr_o, pc_o, sp_o, arg_o, quit_o, act_o, pv_o, pa_o, pd_o};

  // ---------------- reference model (16-bit, 2-byte words) ----------------
  logic [15:0] m_reg [16];
  bit          m_quit, m_active;
  int          m_mode;   // 0 running, 1 saving return PC, 2 quit
  int          m_idx;
  localparam int B = 2;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [114:0] model_vec(input logic [3:0] a);
    return {m_reg[0], m_reg[1], m_reg[2], m_reg[3], m_reg[a], m_quit, m_active,
            m_mode == 1, m_reg[3], m_reg[2]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_reg[i] = 16'h0;
    m_quit = 0; m_active = 0; m_mode = 0; m_idx = 0;
  endtask

  task automatic model_step();
    logic [15:0] pc0, sp0;
    int  dstep;
    bit  take;
    if (m_mode == 0 && !rnr) begin
      pc0 = m_reg[2];
      sp0 = m_reg[3];
      case (m_reg[1][2:1])
        2'd0: dstep = B;
        2'd1: dstep = imin(4, B);
        2'd2: dstep = imin(2, B);
        default: dstep = 1;
      endcase
      take = (ins != INST_QUIT) && m_reg[1][3] && !m_active && (req != 0);
      m_reg[wbi] = wbc;
      if (wbi != 2) m_reg[2] = 16'(pc0 + 1);
      if (ins == INST_PUSH) m_reg[3] = 16'(sp0 + dstep);
      if (ins == INST_POP)  m_reg[3] = 16'(sp0 - dstep);
      if (ins == INST_CALL) m_reg[3] = 16'(sp0 + B);
      if (ins == INST_RET || ins == INST_RETINT) m_reg[3] = 16'(sp0 - B);
      if (ins == INST_RETINT) m_active = 0;
      if (ins == INST_QUIT) begin
        m_quit = 1; m_mode = 2;
      end else if (take) begin
        m_mode = 1;
        for (int i = 3; i >= 0; i--) if (req[i]) m_idx = i;
      end
    end else if (m_mode == 1 && !rnr && rdy) begin
      m_reg[3]  = 16'(m_reg[3] + B);
      m_reg[2]  = 16'(4 + m_idx * 2);
      m_active  = 1;
      m_mode    = 0;
    end
  endtask

  // ---------------- stimulus drivers ----------------
  task automatic step(input logic [7:0] i_ins, input logic [3:0] i_wbi, input logic [15:0] i_wbc,
                      input logic i_rnr, input logic [3:0] i_req, input logic i_rdy);
    ins = i_ins; wbi = i_wbi; wbc = i_wbc; rnr = i_rnr; req = i_req; rdy = i_rdy;
    s_rnr = 1'b1;
    model_step();
    @(posedge clk); #1;
  endtask

  task automatic step32(input logic [7:0] i_ins, input logic [3:0] i_wbi, input logic [31:0] i_wbc);
    rnr = 1'b1;
    s_ins = i_ins; s_wbi = i_wbi; s_wbc = i_wbc; s_rnr = 1'b0;
    @(posedge clk); #1;
    s_rnr = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    model_reset();
    reset = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    n_cmp++;
    if (dut_vec !== model_vec(ins[3:0]) || s_sp !== 32'h0) begin
      n_fail++; $display("FAIL reset_init: dut=%h model=%h sp32=%h", dut_vec, model_vec(ins[3:0]), s_sp);
    end
    step(8'h44, 4'd4, 16'h1234, 0, 4'h0, 0);
    step(8'h45, 4'd5, 16'h0055, 0, 4'h0, 0);
    step(8'h20, 4'd0, 16'h0099, 0, 4'h0, 0);
    // asynchronous reset mid-cycle, checked before any clock edge
    #2 reset = 1'b0;
    #1;
    model_reset();
    n_cmp++;
    if (dut_vec !== model_vec(ins[3:0]) || pc_o !== 16'h0 || wr_o !== 16'h0) begin
      n_fail++; $display("FAIL reset_async: dut=%h model=%h", dut_vec, model_vec(ins[3:0]));
    end
    #1 reset = 1'b1;
    step(8'h44, 4'd4, 16'h1234, 0, 4'h0, 0);
    n_cmp++;
    if (arg_o !== 16'h1234 || pc_o !== 16'h0001) begin
      n_fail++; $display("FAIL first_write: r4=%h pc=%h want 1234 0001", arg_o, pc_o);
    end
  endtask

  task automatic test_sp_wrap();
    step(8'h23, 4'd3, 16'hFFFF, 0, 4'h0, 0);
    step(INST_PUSH, 4'd0, 16'h0000, 0, 4'h0, 0);
    n_cmp++;
    if (sp_o !== 16'h0001 || dut_vec !== model_vec(ins[3:0])) begin
      n_fail++; $display("FAIL sp_wrap: sp=%h want 0001", sp_o);
    end
    step(8'h22, 4'd2, 16'h0040, 0, 4'h0, 0);
    n_cmp++;
    if (pc_o !== 16'h0040 || dut_vec !== model_vec(ins[3:0])) begin
      n_fail++; $display("FAIL pc_write: pc=%h want 0040", pc_o);
    end
  endtask

  task automatic test_step32();
    step32(8'h21, 4'd1, 32'h2);
    step32(8'h23, 4'd3, 32'h100);
    step32(INST_PUSH, 4'd0, 32'h0);
    n_cmp++;
    if (s_sp !== 32'h104) begin n_fail++; $display("FAIL push32_mode01: sp=%h want 104", s_sp); end
    step32(INST_POP, 4'd4, 32'h1);
    n_cmp++;
    if (s_sp !== 32'h100) begin n_fail++; $display("FAIL pop32_mode01: sp=%h want 100", s_sp); end
    step32(8'h21, 4'd1, 32'h6);
    step32(INST_PUSH, 4'd0, 32'h0);
    n_cmp++;
    if (s_sp !== 32'h101) begin n_fail++; $display("FAIL push32_mode11: sp=%h want 101", s_sp); end
    n_cmp++;
    if (dut_vec !== model_vec(ins[3:0])) begin
      n_fail++; $display("FAIL main_hold_32: dut=%h model=%h", dut_vec, model_vec(ins[3:0]));
    end
  endtask

  task automatic test_interrupt();
    step(8'h21, 4'd1, 16'h0008, 0, 4'h0, 0);
    step(8'h22, 4'd2, 16'h0010, 0, 4'h0, 0);
    step(8'h24, 4'd4, 16'hBEEF, 0, 4'b0110, 0);
    for (int c = 0; c < 3; c++) begin
      step(8'h25, 4'd5, 16'h5555, 0, 4'b0110, 0);
      n_cmp++;
      if (pv_o !== 1'b1 || pd_o !== 16'h0011 || pc_o !== 16'h0011 || dut_vec !== model_vec(ins[3:0])) begin
        n_fail++; $display("FAIL int_save_hold: pv=%b data=%h pc=%h want 1 0011 0011", pv_o, pd_o, pc_o);
      end
    end
    step(8'h25, 4'd5, 16'h5555, 0, 4'b0110, 1);
    n_cmp++;
    if (pc_o !== 16'h0006 || act_o !== 1'b1 || pv_o !== 1'b0 || dut_vec !== model_vec(ins[3:0])) begin
      n_fail++; $display("FAIL int_entry: pc=%h act=%b pv=%b want 0006 1 0", pc_o, act_o, pv_o);
    end
    step(8'h26, 4'd6, 16'h0077, 0, 4'b0001, 0);
    n_cmp++;
    if (pv_o !== 1'b0 || pc_o !== 16'h0007 || dut_vec !== model_vec(ins[3:0])) begin
      n_fail++; $display("FAIL no_nesting: pv=%b pc=%h want 0 0007", pv_o, pc_o);
    end
    step(INST_RETINT, 4'd2, 16'h0011, 0, 4'b0001, 0);
    n_cmp++;
    if (pc_o !== 16'h0011 || act_o !== 1'b0 || dut_vec !== model_vec(ins[3:0])) begin
      n_fail++; $display("FAIL retint: pc=%h act=%b want 0011 0", pc_o, act_o);
    end
  endtask

  task automatic test_quit();
    logic [15:0] pc_q;
    step(INST_QUIT, 4'd4, 16'hAAAA, 0, 4'b0001, 0);
    pc_q = m_reg[2];
    n_cmp++;
    if (quit_o !== 1'b1 || pv_o !== 1'b0 || dut_vec !== model_vec(ins[3:0])) begin
      n_fail++; $display("FAIL quit_entry: quit=%b pv=%b want 1 0", quit_o, pv_o);
    end
    for (int c = 0; c < 10; c++) begin
      step(8'($urandom_range(16, 255)), 4'($urandom), 16'($urandom), 0, 4'($urandom), 1'($urandom));
      n_cmp++;
      if (pc_o !== pc_q || pv_o !== 1'b0 || dut_vec !== model_vec(ins[3:0])) begin
        n_fail++; $display("FAIL quit_frozen: dut=%h model=%h", dut_vec, model_vec(ins[3:0]));
      end
    end
  endtask

  task automatic test_ram_hold();
    do_reset();
    step(8'h21, 4'd1, 16'h0008, 0, 4'h0, 0);
    for (int c = 0; c < 5; c++) begin
      step(8'h24, 4'd4, 16'h1357, 1, 4'b1000, 0);
      n_cmp++;
      if (pc_o !== 16'h0001 || pv_o !== 1'b0 || dut_vec !== model_vec(ins[3:0])) begin
        n_fail++; $display("FAIL ram_hold: pc=%h pv=%b want 0001 0", pc_o, pv_o);
      end
    end
    step(8'h24, 4'd4, 16'h1357, 0, 4'b1000, 0);
    n_cmp++;
    if (pv_o !== 1'b1 || pd_o !== 16'h0002 || arg_o !== 16'h1357) begin
      n_fail++; $display("FAIL ram_release: pv=%b data=%h r4=%h want 1 0002 1357", pv_o, pd_o, arg_o);
    end
    for (int c = 0; c < 2; c++) begin
      step(8'h24, 4'd4, 16'h2468, 1, 4'b1000, 1);
      n_cmp++;
      if (pv_o !== 1'b1 || pc_o !== 16'h0002 || dut_vec !== model_vec(ins[3:0])) begin
        n_fail++; $display("FAIL save_hold: pv=%b pc=%h want 1 0002", pv_o, pc_o);
      end
    end
    step(8'h24, 4'd4, 16'h2468, 0, 4'b1000, 1);
    n_cmp++;
    if (pc_o !== 16'h000A || sp_o !== 16'h0002 || act_o !== 1'b1) begin
      n_fail++; $display("FAIL vector3: pc=%h sp=%h act=%b want 000A 0002 1", pc_o, sp_o, act_o);
    end
  endtask

  task automatic test_random();
    logic [7:0] ops [5] = '{INST_PUSH, INST_POP, INST_CALL, INST_RET, INST_RETINT};
    logic [7:0] ri;
    int sel;
    for (int n = 0; n < 400; n++) begin
      sel = $urandom_range(0, 15);
      if (sel < 5) ri = ops[sel];
      else if (sel == 5 && $urandom_range(0, 7) == 0) ri = INST_QUIT;
      else ri = 8'($urandom_range(16, 255));
      step(ri, 4'($urandom), 16'($urandom), $urandom_range(0, 3) == 0,
           ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0, 1'($urandom));
      n_cmp++;
      if (dut_vec !== model_vec(ins[3:0])) begin
        n_fail++; $display("FAIL random[%0d]: dut=%h model=%h", n, dut_vec, model_vec(ins[3:0]));
      end
      if (m_quit && $urandom_range(0, 3) == 0) do_reset();
    end
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    reset = 1'b1;
    test_sp_wrap();
    test_step32();
    test_interrupt();
    test_quit();
    test_ram_hold();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
